// File: rtl/qracc_pkg.sv
// Shared types for the SRAM bank router: FSM state encoding and the shared bank command.
package qracc_pkg;

    localparam int ROW_W_MAX = 16;
    localparam int COLS_MAX  = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    // Sized for the widest supported bank; the router fills the low bits only.
    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [ROW_W_MAX-1:0] addr;
        logic [COLS_MAX-1:0]  wr_data;
    } bank_req_t;

endpackage

// File: rtl/sram_rd_mux.sv
// Selects one bank's read-return valid and data out of the flattened per-bank buses.
module sram_rd_mux #(
    parameter int NUM_BANKS = 4,
    parameter int NUM_COLS  = 32,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic [BANK_W-1:0]             sel,
    input  logic [NUM_BANKS-1:0]          rd_valid,
    input  logic [NUM_BANKS*NUM_COLS-1:0] rd_data,
    output logic                          sel_valid,
    output logic [NUM_COLS-1:0]           sel_data
);

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (sel == BANK_W'(b)) begin
                sel_valid = rd_valid[b];
                sel_data  = rd_data[b*NUM_COLS +: NUM_COLS];
            end
        end
    end

endmodule

// File: rtl/sram_bank_router.sv
// Routes single host requests to one SRAM bank (or all banks for broadcast writes)
// and returns read data from the addressed bank, with a read-return timeout.
//
// state   | meaning
// IDLE    | ready for a host request; illegal requests flagged here
// ISSUE   | per-bank requests outstanding until every pending bank accepts
// WAIT_RD | waiting for the addressed bank's read return or the timeout
module sram_bank_router
    import qracc_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int NUM_ROWS   = 128,
    parameter int NUM_COLS   = 32,
    parameter int RD_TIMEOUT = 64,
    localparam int ROW_W     = $clog2(NUM_ROWS),
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          host_valid_i,
    output logic                          host_ready_o,
    input  logic                          host_wen_i,
    input  logic                          host_bcast_i,
    input  logic [31:0]                   host_addr_i,
    input  logic [NUM_COLS-1:0]           host_wdata_i,
    output logic [NUM_COLS-1:0]           host_rdata_o,
    output logic                          host_rvalid_o,
    output logic                          host_err_o,
    output logic [NUM_BANKS-1:0]          bank_rq_valid_o,
    output logic [NUM_BANKS-1:0]          bank_rq_wr_o,
    output logic [ROW_W-1:0]              bank_addr_o,
    output logic [NUM_COLS-1:0]           bank_wr_data_o,
    input  logic [NUM_BANKS-1:0]          bank_rq_ready_i,
    input  logic [NUM_BANKS-1:0]          bank_rd_valid_i,
    input  logic [NUM_BANKS*NUM_COLS-1:0] bank_rd_data_i
);

    localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [NUM_BANKS-1:0]  pending_q, pending_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [ROW_W-1:0]      row_q;
    logic [BANK_W-1:0]     bank_q;
    logic                  wen_q, bcast_q;
    logic [NUM_COLS-1:0]   wdata_q;
    logic [NUM_COLS-1:0]   rdata_q;
    logic                  err_q, err_d;
    logic                  rvalid_q, rvalid_d;
    logic                  load_rdata;
    logic                  accept;
    logic                  req_illegal;
    logic [BANK_W-1:0]     req_bank;
    logic [NUM_BANKS-1:0]  req_onehot;
    logic                  mux_valid;
    logic [NUM_COLS-1:0]   mux_data;
    bank_req_t             bank_cmd;
    logic                  unused_bits;

    assign host_ready_o = (state_q == IDLE);
    assign accept       = host_valid_i & host_ready_o;
    assign req_bank     = host_addr_i[ROW_W +: BANK_W];
    assign req_onehot   = NUM_BANKS'(1) << req_bank;

    // Bank range only matters for unicast; broadcast reads are never legal.
    assign req_illegal = (|(host_addr_i >> (ROW_W + BANK_W)))
                       | (!host_bcast_i && (32'(req_bank) >= NUM_BANKS))
                       | (host_bcast_i && !host_wen_i);

    sram_rd_mux #(
        .NUM_BANKS (NUM_BANKS),
        .NUM_COLS  (NUM_COLS)
    ) u_rd_mux (
        .sel       (bank_q),
        .rd_valid  (bank_rd_valid_i),
        .rd_data   (bank_rd_data_i),
        .sel_valid (mux_valid),
        .sel_data  (mux_data)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        tmr_d      = tmr_q;
        err_d      = 1'b0;
        rvalid_d   = 1'b0;
        load_rdata = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (host_valid_i) begin
                    if (req_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = ISSUE;
                        pending_d = host_bcast_i ? '1 : req_onehot;
                    end
                end
            end
            ISSUE: begin
                pending_d = pending_q & ~bank_rq_ready_i;
                if (pending_d == '0) begin
                    state_d = wen_q ? IDLE : WAIT_RD;
                    tmr_d   = TMR_W'(RD_TIMEOUT - 1);
                end
            end
            WAIT_RD: begin
                // A return in the final timeout cycle still wins over the error.
                if (mux_valid) begin
                    load_rdata = 1'b1;
                    rvalid_d   = 1'b1;
                    state_d    = IDLE;
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            tmr_q     <= '0;
            row_q     <= '0;
            bank_q    <= '0;
            wen_q     <= 1'b0;
            bcast_q   <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
            rvalid_q  <= rvalid_d;
            if (accept) begin
                row_q   <= host_addr_i[ROW_W-1:0];
                bank_q  <= req_bank;
                wen_q   <= host_wen_i;
                bcast_q <= host_bcast_i;
                wdata_q <= host_wdata_i;
            end
            if (load_rdata) begin
                rdata_q <= mux_data;
            end
        end
    end

    always_comb begin
        bank_cmd                        = '0;
        bank_cmd.valid                  = (state_q == ISSUE);
        bank_cmd.wr                     = wen_q;
        bank_cmd.addr[ROW_W-1:0]        = row_q;
        bank_cmd.wr_data[NUM_COLS-1:0]  = wdata_q;
    end

    assign bank_rq_valid_o = bank_cmd.valid ? pending_q : '0;
    assign bank_rq_wr_o    = (bank_cmd.valid && bank_cmd.wr) ? pending_q : '0;
    assign bank_addr_o     = bank_cmd.addr[ROW_W-1:0];
    assign bank_wr_data_o  = bank_cmd.wr_data[NUM_COLS-1:0];
    assign host_rdata_o    = rdata_q;
    assign host_rvalid_o   = rvalid_q;
    assign host_err_o      = err_q;

    // Upper struct bits are constant zero and bcast is fully captured by the pending mask.
    assign unused_bits = ^{bank_cmd, bcast_q};

endmodule
